dsp_mac_sequencer: RTL
======================

# dsp_mac_sequencer

Sequencer that drives a DSP48A1-style slice as a dot-product engine. It accepts a job command (length and 48-bit bias) and a valid/ready stream of 18-bit operand pairs. It issues operands and time-aligned opmode/C words to the slice, tracks the slice pipeline, and returns the accumulated P value on a valid/ready result port. It sits directly in front of the slice instance and owns all of its A/B/C/opmode/CE/reset inputs.

## Interface
- LEN_W, 8, width of job length field
- LAT, 3, cycles from operand issue to P holding that operand's accumulation (matches slice build A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=1)
- OPM_DLY, 1, cycles opmode/C lag operand issue (matches OPMODEREG=CREG=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid / cmd_ready  in / out  1  job handshake
- cmd_len  in  LEN_W  number of operand pairs (0 allowed)
- cmd_bias  in  48  initial accumulator value
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  18  operand pair (unsigned)
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  48  final accumulation
- res_ovf  out  1  sticky carry-out over the job
- dsp_a, dsp_b  out  18  to slice A, B
- dsp_c  out  48  to slice C
- dsp_opmode  out  8  to slice opmode
- dsp_ce  out  1  common clock enable for all slice CE inputs
- dsp_rst  out  1  active-high reset to all slice RST inputs
- dsp_p  in  48  slice P
- dsp_carryout  in  1  slice CARRYOUT

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch len and bias, clear issue count and ovf, and go to RUN. If len=0, go straight to DRAIN after issuing one bias-only slot.
- RUN: in_ready=1 while issued<len. Each cycle issues exactly one slot, aligned OPM_DLY cycles later on opmode/C:
  - first accepted pair: opmode 8'h0D (Z=C, X=M, add, carry 0), dsp_c=bias
  - later pairs: 8'h09 (Z=P, X=M)
  - no pair accepted: bubble 8'h08 (Z=P, X=0), dsp_a/b=0. A bubble before the first pair is harmless because the first pair reloads from C.
  - len=0 slot: 8'h0C (Z=C, X=0)
- The issue accepting the last pair moves the FSM to DRAIN.
- DRAIN: keep issuing bubbles. A LAT-deep tag pipeline marks the last slot. When the tag exits, capture dsp_p into res_data and go to DONE.
- DONE: res_valid=1, and res_data/res_ovf are held stable. On res_ready, go to IDLE. No new command is accepted before then.
- Arithmetic: modulo 2^48. Operands are unsigned. The pre-adder is never used (opmode bits 4 and 6 are 0). Bit 7 is 0 (add).
- Reset (rst_n=0 on an edge), from any state including mid-job: state IDLE, cmd_ready=0, in_ready=0, res_valid=0, res_data=0, res_ovf=0, dsp_a/b/c=0, dsp_opmode=8'h00, dsp_ce=0, dsp_rst=1. After release, dsp_ce=1, dsp_rst=0 and cmd_ready=1 from the next cycle. Any in-flight job is discarded.

## Timing
- Pair accepted at cycle t: dsp_a/b are driven at t; opmode/C at t+OPM_DLY; P holds that accumulation at t+LAT.
- Back-to-back pairs sustain 1 pair/cycle.
- Last pair accepted at t: res_valid rises at t+LAT+1.
- len=0: res_valid rises LAT+1 cycles after cmd acceptance.
- cmd_ready deasserts the cycle after acceptance. It is reasserted the cycle after the res handshake.
- res_valid and res_ready high in the same cycle completes the job in that cycle.

## Configuration
- DSP_MAC_OVF_EN defined: res_ovf ORs in dsp_carryout each cycle a non-bubble slot exits the tag pipeline. It is cleared on cmd acceptance.
- DSP_MAC_OVF_EN undefined: res_ovf is constant 0 and no carry logic is built.

## Structure
- Package dsp_mac_pkg: opmode constants OPM_FIRST=8'h0D, OPM_ACC=8'h09, OPM_BUBBLE=8'h08, OPM_BIAS=8'h0C; state enum; P width 48 and operand width 18.
- Sub-module dsp_issue_delay: parameterised shift register that delays {opmode,C} by OPM_DLY and {valid,real,last} tags by LAT. It resets to zeros and bubble opmode.

## Test plan
- len=3, bias=10, pairs (2,3),(4,5),(6,7) back-to-back -> res_data=78, res_valid at last-accept+4, res_ovf=0.
- Same job with 2-cycle in_valid gaps between pairs -> res_data=78, bubbles observed as opmode 8'h08.
- len=0, bias=48'h123 -> one 8'h0C slot, res_data=48'h123 after 4 cycles.
- res_ready held low 5 cycles in DONE -> res_data stable, cmd_ready=0, in_ready=0; completes on first res_ready.
- rst_n low for 1 cycle mid-RUN -> next cycle all outputs at reset values, dsp_rst=1; a fresh job afterwards returns the correct result.
- With DSP_MAC_OVF_EN defined: bias=48'hFFFF_FFFF_FFFF, pair (1,1) -> res_data=0, res_ovf=1.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP48A1 dot-product sequencer.
package dsp_mac_pkg;

    localparam int P_W  = 48;
    localparam int OP_W = 18;

    localparam logic [7:0] OPM_FIRST  = 8'h0D;
    localparam logic [7:0] OPM_ACC    = 8'h09;
    localparam logic [7:0] OPM_BUBBLE = 8'h08;
    localparam logic [7:0] OPM_BIAS   = 8'h0C;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Per-slot bookkeeping that travels alongside the slice pipeline
    typedef struct packed {
        logic vld;
        logic is_real;
        logic last;
    } tag_t;

    function automatic logic [7:0] pair_opmode(input logic first);
        return first ? OPM_FIRST : OPM_ACC;
    endfunction

endpackage

// File: rtl/dsp_issue_delay.sv
// Aligns {opmode,C} with the slice input registers and tracks slot tags
// through the slice latency.
module dsp_issue_delay
    import dsp_mac_pkg::*;
#(
    parameter int OPM_DLY = 1,
    parameter int LAT     = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     opm_i,
    input  logic [P_W-1:0] c_i,
    input  tag_t           tag_i,
    output logic [7:0]     opm_o,
    output logic [P_W-1:0] c_o,
    output tag_t           tag_o
);

    logic [OPM_DLY-1:0][7:0]     opm_q;
    logic [OPM_DLY-1:0][P_W-1:0] c_q;
    tag_t [LAT-1:0]              tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opm_q <= {OPM_DLY{OPM_BUBBLE}};
            c_q   <= '0;
        end else begin
            opm_q[0] <= opm_i;
            c_q[0]   <= c_i;
            for (int i = 1; i < OPM_DLY; i++) begin
                opm_q[i] <= opm_q[i-1];
                c_q[i]   <= c_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign opm_o = opm_q[OPM_DLY-1];
    assign c_o   = c_q[OPM_DLY-1];
    assign tag_o = tag_q[LAT-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer driving a DSP48A1-style slice.
// Define DSP_MAC_OVF_EN to build the sticky carry-out (res_ovf) tracking.
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [P_W-1:0]    cmd_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [P_W-1:0]    res_data,
    output logic              res_ovf,
    output logic [OP_W-1:0]   dsp_a,
    output logic [OP_W-1:0]   dsp_b,
    output logic [P_W-1:0]    dsp_c,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_ce,
    output logic              dsp_rst,
    input  logic [P_W-1:0]    dsp_p,
    input  logic              dsp_carryout
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [P_W-1:0]   bias_q, bias_d;
    logic [P_W-1:0]   res_data_q, res_data_d;
    logic             ce_q, rst_q;

    logic [7:0]       slot_opm, opm_dly;
    logic [P_W-1:0]   slot_c, c_dly;
    tag_t             slot_tag, tag_out;
    logic             cmd_acc, in_acc;

    assign cmd_ready = ce_q && (state_q == S_IDLE);
    assign in_ready  = (state_q == S_RUN) && (issued_q != len_q);
    assign res_valid = (state_q == S_DONE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign in_acc    = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bias_d     = bias_q;
        issued_d   = issued_q;
        res_data_d = res_data_q;
        slot_opm   = OPM_BUBBLE;
        slot_c     = '0;
        slot_tag   = '0;
        dsp_a      = '0;
        dsp_b      = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    len_d    = cmd_len;
                    bias_d   = cmd_bias;
                    issued_d = '0;
                    // Empty job: a single C-only slot loads the bias into P
                    if (cmd_len == '0) begin
                        slot_opm = OPM_BIAS;
                        slot_c   = cmd_bias;
                        slot_tag = '{vld: 1'b1, is_real: 1'b1, last: 1'b1};
                        state_d  = S_DRAIN;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                slot_tag.vld = 1'b1;
                if (in_acc) begin
                    dsp_a            = in_a;
                    dsp_b            = in_b;
                    issued_d         = issued_q + LEN_W'(1);
                    slot_tag.is_real = 1'b1;
                    slot_opm         = pair_opmode(issued_q == '0);
                    if (issued_q == '0) slot_c = bias_q;
                    if (issued_q == len_q - LEN_W'(1)) begin
                        slot_tag.last = 1'b1;
                        state_d       = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                slot_tag.vld = 1'b1;
                if (tag_out.last) begin
                    res_data_d = dsp_p;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            bias_q     <= '0;
            res_data_q <= '0;
            ce_q       <= 1'b0;
            rst_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            bias_q     <= bias_d;
            res_data_q <= res_data_d;
            ce_q       <= 1'b1;
            rst_q      <= 1'b0;
        end
    end

    dsp_issue_delay #(
        .OPM_DLY (OPM_DLY),
        .LAT     (LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .opm_i (slot_opm),
        .c_i   (slot_c),
        .tag_i (slot_tag),
        .opm_o (opm_dly),
        .c_o   (c_dly),
        .tag_o (tag_out)
    );

`ifdef DSP_MAC_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (cmd_acc) ovf_d = 1'b0;
        else if (tag_out.is_real && dsp_carryout) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    logic unused_sig;
    assign unused_sig = ^{tag_out.vld, tag_out.is_real, dsp_carryout};

    // Slice sees opmode 0 while held in reset, bubbles once running
    assign dsp_opmode = ce_q ? opm_dly : 8'h00;
    assign dsp_c      = c_dly;
    assign dsp_ce     = ce_q;
    assign dsp_rst    = rst_q;
    assign res_data   = res_data_q;

endmodule
